// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer over a valid/ready imem port.
// Fetches one instruction at a time, presents it to decode, and advances to nextPc on retire.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  i_nextPc,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pcPlus4,
  output logic               o_imemReqValid,
  output logic [ADDR_W-1:0]  o_imemReqAddr,
  input  logic               i_imemReqReady,
  input  logic               i_imemRespValid,
  input  logic [INSTR_W-1:0] i_imemRespData,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instrValid,
  input  logic               i_instrReady,
  output logic               o_fault,
  output logic [31:0]        o_fetchCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_reqValid;
  logic                r_instrValid;
  logic                r_fault;
  logic [31:0]         r_fetchCount;
  logic                w_nextAligned;

  assign w_nextAligned = (i_nextPc[1:0] == 2'b00);

  // Responses are only captured in ST_WAIT, so stray or zero-latency pulses never reach decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_reqValid   <= 1'b0;
      r_instrValid <= 1'b0;
      r_fault      <= 1'b0;
      r_fetchCount <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_reqValid <= 1'b1;
        end
        ST_REQ: begin
          if (i_imemReqReady) begin
            r_state    <= ST_WAIT;
            r_reqValid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_imemRespValid) begin
            r_state      <= ST_HOLD;
            r_instr      <= i_imemRespData;
            r_instrValid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_instrReady) begin
            r_pc         <= i_nextPc;
            r_fetchCount <= r_fetchCount + 32'd1;
            r_instrValid <= 1'b0;
            // A misaligned target is kept in pc so software can see what went wrong.
            if (w_nextAligned) begin
              r_state    <= ST_REQ;
              r_reqValid <= 1'b1;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          r_reqValid   <= 1'b0;
          r_instrValid <= 1'b0;
          r_fault      <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_reqValid   <= 1'b0;
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc           = r_pc;
  assign o_pcPlus4      = r_pc + ADDR_W'(4);
  assign o_imemReqValid = r_reqValid;
  assign o_imemReqAddr  = r_pc;
  assign o_instr        = r_instr;
  assign o_instrValid   = r_instrValid;
  assign o_fault        = r_fault;
  assign o_fetchCount   = r_fetchCount;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a memory model answers fetches, a monitor
// checks accepted request addresses and retired instructions against queued expectations.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_nextPc;
  logic [31:0] o_pc;
  logic [31:0] o_pcPlus4;
  logic        o_imemReqValid;
  logic [31:0] o_imemReqAddr;
  logic        i_imemReqReady;
  logic        i_imemRespValid;
  logic [31:0] i_imemRespData;
  logic [31:0] o_instr;
  logic        o_instrValid;
  logic        i_instrReady;
  logic        o_fault;
  logic [31:0] o_fetchCount;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } retire_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expReqQ[$];
  retire_t     expRetQ[$];
  logic        glitch  = 1'b0;
  logic        memMute = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_nextPc       (i_nextPc),
    .o_pc           (o_pc),
    .o_pcPlus4      (o_pcPlus4),
    .o_imemReqValid (o_imemReqValid),
    .o_imemReqAddr  (o_imemReqAddr),
    .i_imemReqReady (i_imemReqReady),
    .i_imemRespValid(i_imemRespValid),
    .i_imemRespData (i_imemRespData),
    .o_instr        (o_instr),
    .o_instrValid   (o_instrValid),
    .i_instrReady   (i_instrReady),
    .o_fault        (o_fault),
    .o_fetchCount   (o_fetchCount)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'h0050_0093 : (addr ^ 32'h5A5A_0013);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] nextPc, input logic reqReady, input logic instrReady);
    i_nextPc       = nextPc;
    i_imemReqReady = reqReady;
    i_instrReady   = instrReady;
  endtask

  task automatic waitInstr();
    int n = 0;
    while (!o_instrValid && n < 20) begin
      step();
      n++;
    end
    checkOutput("instrValidTimeout", {31'b0, o_instrValid}, 32'h1);
  endtask

  // Wait for the held instruction, then retire it toward nextPc.
  task automatic fetchRetire(input logic [31:0] nextPc, input logic reqReadyAfter);
    waitInstr();
    i_nextPc       = nextPc;
    i_imemReqReady = reqReadyAfter;
    step();
  endtask

  // Memory answers one cycle after accept; glitch injects stray response pulses.
  initial begin : memModel
    logic        pend;
    logic [31:0] addr;
    i_imemRespValid = 1'b0;
    i_imemRespData  = 32'h0;
    forever begin
      @(negedge clk);
      pend = o_imemReqValid && i_imemReqReady && !memMute;
      addr = o_imemReqAddr;
      @(posedge clk);
      #1;
      i_imemRespValid = pend || glitch;
      i_imemRespData  = pend ? memWord(addr) : 32'hDEAD_BEEF;
    end
  end

  initial begin : monitor
    retire_t exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_imemReqValid && i_imemReqReady) begin
          if (expReqQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL reqAccept: got request at 0x%08h expected none", o_imemReqAddr);
          end else begin
            checkOutput("reqAddr", o_imemReqAddr, expReqQ.pop_front());
          end
        end
        if (o_instrValid && i_instrReady) begin
          if (expRetQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL retire: got retire of 0x%08h expected none", o_instr);
          end else begin
            exp = expRetQ.pop_front();
            checkOutput("retireInstr", o_instr, exp.instr);
            checkOutput("retirePc", o_pc, exp.pc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0);
    repeat (3) step();

    // Reset state
    checkOutput("rstPc", o_pc, 32'h0);
    checkOutput("rstReqValid", {31'b0, o_imemReqValid}, 32'h0);
    checkOutput("rstInstrValid", {31'b0, o_instrValid}, 32'h0);
    checkOutput("rstFetchCount", o_fetchCount, 32'h0);
    checkOutput("rstFault", {31'b0, o_fault}, 32'h0);

    expReqQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44};
    expRetQ = '{'{32'h0, 32'h0050_0093}, '{32'h4, 32'h5A5A_0017}, '{32'h8, 32'h5A5A_001B},
                '{32'hC, 32'h5A5A_001F}, '{32'h10, 32'h5A5A_0003}, '{32'h40, 32'h5A5A_0053},
                '{32'h44, 32'h5A5A_0057}};

    applyStimulus(32'h0, 1'b1, 1'b1);
    rst_n = 1'b1;
    checkOutput("idleBubble", {31'b0, o_imemReqValid}, 32'h0);
    step();
    checkOutput("firstReqValid", {31'b0, o_imemReqValid}, 32'h1);
    checkOutput("firstReqAddr", o_imemReqAddr, 32'h0);

    // Sequential fetch
    fetchRetire(32'h4, 1'b1);
    checkOutput("seqPc4", o_pc, 32'h4);
    checkOutput("instrDropAfterRetire", {31'b0, o_instrValid}, 32'h0);
    checkOutput("reqAfterRetire", {31'b0, o_imemReqValid}, 32'h1);
    checkOutput("pcPlus4", o_pcPlus4, 32'h8);
    fetchRetire(32'h8, 1'b1);
    checkOutput("seqPc8", o_pc, 32'h8);
    checkOutput("seqCount2", o_fetchCount, 32'h2);

    // Branch from 0x10 to 0x40, then hold the request off
    fetchRetire(32'hC, 1'b1);
    fetchRetire(32'h10, 1'b1);
    fetchRetire(32'h40, 1'b0);
    checkOutput("branchPc", o_pc, 32'h40);
    for (int i = 0; i < 5; i++) begin
      glitch = (i == 0);
      checkOutput("stallReqValid", {31'b0, o_imemReqValid}, 32'h1);
      checkOutput("stallReqAddr", o_imemReqAddr, 32'h40);
      step();
    end
    glitch = 1'b0;

    applyStimulus(32'h44, 1'b1, 1'b0);
    waitInstr();
    for (int i = 0; i < 4; i++) begin
      glitch = (i == 0);
      checkOutput("holdInstrValid", {31'b0, o_instrValid}, 32'h1);
      checkOutput("holdInstr", o_instr, 32'h5A5A_0053);
      checkOutput("holdPc", o_pc, 32'h40);
      checkOutput("holdCount", o_fetchCount, 32'h5);
      step();
    end
    glitch = 1'b0;
    i_instrReady = 1'b1;
    step();
    checkOutput("countAfterHold", o_fetchCount, 32'h6);

    // Misaligned target
    fetchRetire(32'h42, 1'b1);
    checkOutput("faultSet", {31'b0, o_fault}, 32'h1);
    checkOutput("faultPc", o_pc, 32'h42);
    checkOutput("faultPcPlus4", o_pcPlus4, 32'h46);
    checkOutput("faultCount", o_fetchCount, 32'h7);
    repeat (3) step();
    checkOutput("faultNoReq", {31'b0, o_imemReqValid}, 32'h0);
    checkOutput("faultNoInstr", {31'b0, o_instrValid}, 32'h0);
    checkOutput("faultSticky", {31'b0, o_fault}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("faultClear", {31'b0, o_fault}, 32'h0);
    checkOutput("faultRstPc", o_pc, 32'h0);
    checkOutput("faultRstCount", o_fetchCount, 32'h0);

    // Reset while waiting for a response that never comes
    memMute = 1'b1;
    expReqQ.push_back(32'h0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    checkOutput("waitNoReq", {31'b0, o_imemReqValid}, 32'h0);
    checkOutput("waitNoInstr", {31'b0, o_instrValid}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("midWaitRstPc", o_pc, 32'h0);
    checkOutput("midWaitRstReq", {31'b0, o_imemReqValid}, 32'h0);
    checkOutput("midWaitRstInstr", o_instr, 32'h0);
    memMute = 1'b0;
    expReqQ.push_back(32'h0);
    expReqQ.push_back(32'hFFFF_FFFC);
    expRetQ.push_back('{32'h0, 32'h0050_0093});
    expRetQ.push_back('{32'hFFFF_FFFC, 32'hA5A5_FFEF});
    step();
    rst_n = 1'b1;

    // Wrap of pc and fetchCount
    fetchRetire(32'hFFFF_FFFC, 1'b1);
    i_instrReady = 1'b0;
    checkOutput("wrapSetupPc", o_pc, 32'hFFFF_FFFC);
    checkOutput("wrapSetupCount", o_fetchCount, 32'h1);
    waitInstr();
    dut.r_fetchCount = 32'hFFFF_FFFF;
    step();
    checkOutput("wrapPreCount", o_fetchCount, 32'hFFFF_FFFF);
    checkOutput("wrapPcPlus4", o_pcPlus4, 32'h0);
    expReqQ.push_back(32'h0);
    applyStimulus(32'h0, 1'b1, 1'b1);
    step();
    i_instrReady = 1'b0;
    checkOutput("wrapPc", o_pc, 32'h0);
    checkOutput("wrapCount", o_fetchCount, 32'h0);
    checkOutput("wrapReqValid", {31'b0, o_imemReqValid}, 32'h1);
    checkOutput("wrapReqAddr", o_imemReqAddr, 32'h0);
    repeat (4) step();

    checkOutput("reqQueueDrained", expReqQ.size(), 32'h0);
    checkOutput("retQueueDrained", expRetQ.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
